// File: rtl/structures.sv
// ---------------------------------------------------------------------------
// structures: types shared by the L1 caches and the line-granular backing
// memory.
//   mem_bus_req_t    : line request from an L1 (load/store strobes, line address,
//                      write line)
//   mem_bus_resp_t   : line response to an L1 (ready pulse, read line)
//   MEM_LINE_BITS    : width of one memory line
//   mem_line_state_t : main_mem_line control states
// ---------------------------------------------------------------------------
package structures;

    localparam int CACHE_LINE_SIZE = 512;
    localparam int MEM_LINE_BITS   = 512;
    localparam int MEM_ADDR_BITS   = 32;

    typedef struct packed {
        logic                       mem_req_load;
        logic                       mem_req_store;
        logic [MEM_ADDR_BITS-1:0]   mem_addr;      // line address (byte address >> 6)
        logic [CACHE_LINE_SIZE-1:0] mem_data_out;  // line to write
    } mem_bus_req_t;

    typedef struct packed {
        logic                       mem_ready;
        logic [CACHE_LINE_SIZE-1:0] mem_data;
    } mem_bus_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP,
        DONE
    } mem_line_state_t;

endpackage

// File: rtl/line_ram.sv
// ---------------------------------------------------------------------------
// line_ram: single-port DEPTH x LINE_BITS line store, synchronous write and
// synchronous (registered) read.
//   clock : clock
//   en    : access strobe for this edge
//   we    : 1 = write wdata to index, 0 = register mem[index] into rdata
//   index : line index
//   wdata : line to write
//   rdata : registered read line (holds between reads)
// ---------------------------------------------------------------------------
module line_ram #(
    parameter int    LINE_BITS = 512,
    parameter int    DEPTH     = 1024,
    parameter string INIT_FILE = "",
    localparam int   IDX_BITS  = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 en,
    input  logic                 we,
    input  logic [IDX_BITS-1:0]  index,
    input  logic [LINE_BITS-1:0] wdata,
    output logic [LINE_BITS-1:0] rdata
);

    logic [LINE_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem[index] <= wdata;
            end else begin
                rdata <= mem[index];
            end
        end
    end

endmodule

// File: rtl/main_mem_line.sv
// ---------------------------------------------------------------------------
// main_mem_line: line-granular backing memory shared by the instruction L1
// (client 0) and data L1 (client 1). Round-robin arbitration, one request in
// flight, fixed LATENCY from acceptance to a one-cycle mem_ready pulse.
//   clock       : clock
//   reset       : synchronous, active-low
//   req0 / resp0: client 0 request / response
//   req1 / resp1: client 1 request / response
// ---------------------------------------------------------------------------
module main_mem_line
    import structures::*;
#(
    parameter int    LINE_BITS = MEM_LINE_BITS,
    parameter int    DEPTH     = 1024,
    parameter int    LATENCY   = 4,
    parameter string INIT_FILE = ""
) (
    input  logic          clock,
    input  logic          reset,
    input  mem_bus_req_t  req0,
    output mem_bus_resp_t resp0,
    input  mem_bus_req_t  req1,
    output mem_bus_resp_t resp1
);

    localparam int IDX_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = $clog2(LATENCY + 1);
    localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);

    mem_line_state_t      state_reg;
    logic [CNT_BITS-1:0]  cnt_reg;
    logic                 client_reg;
    logic                 store_reg;
    logic                 last_grant_reg;
    logic [IDX_BITS-1:0]  index_reg;
    logic [LINE_BITS-1:0] wdata_reg;
    logic                 ready0_reg;
    logic                 ready1_reg;
    logic [LINE_BITS-1:0] data0_reg;
    logic [LINE_BITS-1:0] data1_reg;
    logic [LINE_BITS-1:0] ram_rdata;

    logic want0;
    logic want1;
    logic grant1;
    logic resp_entry;
    logic unused_addr_bits;

    assign want0  = req0.mem_req_load | req0.mem_req_store;
    assign want1  = req1.mem_req_load | req1.mem_req_store;
    // Client 1 wins when alone, or on a tie when client 0 was served last.
    assign grant1 = want1 & (~want0 | ~last_grant_reg);

    // The edge that moves BUSY -> RESP performs the array access; reset on
    // that same edge must suppress it, hence the reset term.
    assign resp_entry = reset & (state_reg == BUSY) & (cnt_reg == '0);

    // Upper address bits alias away by design.
    assign unused_addr_bits = ^{req0.mem_addr[MEM_ADDR_BITS-1:IDX_BITS],
                                req1.mem_addr[MEM_ADDR_BITS-1:IDX_BITS]};

    line_ram #(
        .LINE_BITS (LINE_BITS),
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_line_ram (
        .clock (clock),
        .en    (resp_entry),
        .we    (store_reg),
        .index (index_reg),
        .wdata (wdata_reg),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg      <= IDLE;
            ready0_reg     <= 1'b0;
            ready1_reg     <= 1'b0;
            data0_reg      <= '0;
            data1_reg      <= '0;
            last_grant_reg <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (want0 | want1) begin
                        client_reg <= grant1;
                        if (grant1) begin
                            // store wins when both strobes are high
                            store_reg <= req1.mem_req_store;
                            index_reg <= req1.mem_addr[IDX_BITS-1:0];
                            wdata_reg <= req1.mem_data_out;
                        end else begin
                            store_reg <= req0.mem_req_store;
                            index_reg <= req0.mem_addr[IDX_BITS-1:0];
                            wdata_reg <= req0.mem_data_out;
                        end
                        cnt_reg   <= CNT_LOAD;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_reg == '0) begin
                        state_reg <= RESP;
                        if (client_reg) begin
                            ready1_reg <= 1'b1;
                        end else begin
                            ready0_reg <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                RESP: begin
                    state_reg  <= DONE;
                    ready0_reg <= 1'b0;
                    ready1_reg <= 1'b0;
                    // Capture the read line so it persists after the RAM's
                    // output register is reused by the other client.
                    if (!store_reg) begin
                        if (client_reg) begin
                            data1_reg <= ram_rdata;
                        end else begin
                            data0_reg <= ram_rdata;
                        end
                    end
                end
                DONE: begin
                    // The served client's request is still high here, so no
                    // arbitration on this edge.
                    last_grant_reg <= client_reg;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // During the ready cycle of a load the line comes straight from the RAM
    // output register; otherwise each client sees its own held line.
    assign resp0.mem_ready = ready0_reg;
    assign resp0.mem_data  = (ready0_reg && !store_reg) ? ram_rdata : data0_reg;
    assign resp1.mem_ready = ready1_reg;
    assign resp1.mem_data  = (ready1_reg && !store_reg) ? ram_rdata : data1_reg;

endmodule

// File: tb/tb_main_mem_line.sv
// ---------------------------------------------------------------------------
// tb_main_mem_line: bench for main_mem_line. Two instances: LATENCY=4 /
// DEPTH=1024 and LATENCY=1 / DEPTH=64. A behavioural model (line contents by
// index, last-served client, per-client held data) predicts every response.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_main_mem_line;
    import structures::*;

    typedef logic [MEM_LINE_BITS-1:0] line_t;

    localparam int DEPTH0 = 1024;
    localparam int LAT0   = 4;
    localparam int DEPTH1 = 64;
    localparam int LAT1   = 1;

    logic          clock = 1'b0;
    logic          rst   [2];
    mem_bus_req_t  req0  [2];
    mem_bus_req_t  req1  [2];
    mem_bus_resp_t resp0 [2];
    mem_bus_resp_t resp1 [2];

    always #5 clock = ~clock;

    main_mem_line #(
        .LINE_BITS (MEM_LINE_BITS),
        .DEPTH     (DEPTH0),
        .LATENCY   (LAT0),
        .INIT_FILE ("")
    ) u_dut (
        .clock (clock),
        .reset (rst[0]),
        .req0  (req0[0]),
        .resp0 (resp0[0]),
        .req1  (req1[0]),
        .resp1 (resp1[0])
    );

    main_mem_line #(
        .LINE_BITS (MEM_LINE_BITS),
        .DEPTH     (DEPTH1),
        .LATENCY   (LAT1),
        .INIT_FILE ("")
    ) u_dut_lat1 (
        .clock (clock),
        .reset (rst[1]),
        .req0  (req0[1]),
        .resp0 (resp0[1]),
        .req1  (req1[1]),
        .resp1 (resp1[1])
    );

    // Reference model
    line_t mdl [int];            // key = dut*65536 + line index
    int    last_served [2];
    line_t exp_data [2][2];      // [dut][client] data each client should show

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    function automatic int depth_of(input int sel);
        return (sel != 0) ? DEPTH1 : DEPTH0;
    endfunction

    function automatic int lat_of(input int sel);
        return (sel != 0) ? LAT1 : LAT0;
    endfunction

    function automatic logic rdy(input int sel, input int c);
        return (c != 0) ? resp1[sel].mem_ready : resp0[sel].mem_ready;
    endfunction

    function automatic line_t rdat(input int sel, input int c);
        return (c != 0) ? resp1[sel].mem_data : resp0[sel].mem_data;
    endfunction

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < MEM_LINE_BITS / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic chk(input string tag, input line_t obs, input line_t expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive(input int sel, input int c, input logic ld, input logic st,
                         input logic [31:0] a, input line_t d);
        mem_bus_req_t r;
        r.mem_req_load  = ld;
        r.mem_req_store = st;
        r.mem_addr      = a;
        r.mem_data_out  = d;
        if (c != 0) req1[sel] = r;
        else        req0[sel] = r;
    endtask

    task automatic do_reset(input int sel);
        drive(sel, 0, 1'b0, 1'b0, 32'd0, '0);
        drive(sel, 1, 1'b0, 1'b0, 32'd0, '0);
        rst[sel] = 1'b0;
        @(negedge clock);
        @(negedge clock);
        rst[sel] = 1'b1;
        last_served[sel]  = 1;
        exp_data[sel][0]  = '0;
        exp_data[sel][1]  = '0;
        chk("reset_ready0", line_t'(rdy(sel, 0)), '0);
        chk("reset_ready1", line_t'(rdy(sel, 1)), '0);
        chk("reset_data0", rdat(sel, 0), '0);
        chk("reset_data1", rdat(sel, 1), '0);
        $display("reset dut%0d", sel);
    endtask

    // One transaction round: client 0 and/or client 1 raise a request on the
    // same cycle and hold it until they see their own mem_ready.
    task automatic txn(input int sel, input bit en0, input bit en1,
                       input bit st0, input bit st1,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input line_t d0, input line_t d1);
        int          lat;
        bit          en [2];
        bit          st [2];
        logic [31:0] a  [2];
        line_t       d  [2];
        int          first [2];
        int          hi [2];
        int          win;
        int          lose;
        int          key;
        int          last_seen;
        lat = lat_of(sel);
        en[0] = en0; en[1] = en1;
        st[0] = st0; st[1] = st1;
        a[0]  = a0;  a[1]  = a1;
        d[0]  = d0;  d[1]  = d1;
        first[0] = -1; first[1] = -1;
        hi[0] = 0; hi[1] = 0;
        last_seen = 0;
        win  = (en0 && en1) ? (1 - last_served[sel]) : (en1 ? 1 : 0);
        lose = 1 - win;
        for (int c = 0; c < 2; c++)
            if (en[c]) drive(sel, c, !st[c], st[c], a[c], d[c]);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            for (int c = 0; c < 2; c++) begin
                if (rdy(sel, c)) begin
                    hi[c]++;
                    if (first[c] < 0) begin
                        first[c]  = n;
                        last_seen = n;
                        key = sel * 65536 + int'(a[c] % depth_of(sel));
                        if (st[c]) begin
                            mdl[key] = d[c];
                        end else begin
                            exp_data[sel][c] = mdl[key];
                            chk(c ? "load_data1" : "load_data0", rdat(sel, c), mdl[key]);
                        end
                        last_served[sel] = c;
                        drive(sel, c, 1'b0, 1'b0, 32'd0, '0);
                    end
                end
            end
            if ((!en[0] || first[0] > 0) && (!en[1] || first[1] > 0) && n >= last_seen + 2)
                break;
        end
        chk("first_latency", line_t'(first[win]), line_t'(lat + 1));
        if (en0 && en1)
            chk("second_accept_window",
                line_t'(first[lose] >= 2 * lat + 3 && first[lose] <= 2 * lat + 4), line_t'(1));
        chk("pulses0", line_t'(hi[0]), line_t'(en0 ? 1 : 0));
        chk("pulses1", line_t'(hi[1]), line_t'(en1 ? 1 : 0));
        chk("hold_data0", rdat(sel, 0), exp_data[sel][0]);
        chk("hold_data1", rdat(sel, 1), exp_data[sel][1]);
        // Drop any request still high after a timed-out round.
        drive(sel, 0, 1'b0, 1'b0, 32'd0, '0);
        drive(sel, 1, 1'b0, 1'b0, 32'd0, '0);
        $display("txn dut%0d c0[en=%0b st=%0b a=%0d] c1[en=%0b st=%0b a=%0d] ready at c0=%0d c1=%0d",
                 sel, en0, st0, a0, en1, st1, a1, first[0], first[1]);
    endtask

    // Store that reset aborts: reset is driven so that the rst_at-th edge after
    // acceptance sees it; no pulse may appear and the line must not change.
    task automatic abort_store(input int sel, input int c, input logic [31:0] a,
                               input line_t d, input int rst_at);
        int hi;
        hi = 0;
        drive(sel, c, 1'b0, 1'b1, a, d);
        for (int n = 1; n <= lat_of(sel) + 4; n++) begin
            @(negedge clock);
            if (rdy(sel, 0) || rdy(sel, 1)) hi++;
            if (n == rst_at) begin
                rst[sel] = 1'b0;
                drive(sel, c, 1'b0, 1'b0, 32'd0, '0);
            end
            if (n == rst_at + 2) rst[sel] = 1'b1;
        end
        last_served[sel] = 1;
        exp_data[sel][0] = '0;
        exp_data[sel][1] = '0;
        chk("abort_no_ready", line_t'(hi), '0);
        chk("abort_data0", rdat(sel, 0), '0);
        chk("abort_data1", rdat(sel, 1), '0);
        $display("abort dut%0d store a=%0d reset at edge +%0d", sel, a, rst_at);
    endtask

    initial begin
        line_t pat_a5;
        line_t pat_3c;
        line_t old9;
        line_t old11;
        pat_a5 = {64{8'hA5}};
        pat_3c = {64{8'h3C}};
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        for (int s = 0; s < 2; s++) begin
            drive(s, 0, 1'b0, 1'b0, 32'd0, '0);
            drive(s, 1, 1'b0, 1'b0, 32'd0, '0);
        end
        @(negedge clock);
        do_reset(0);
        do_reset(1);

        // Line 5 pattern, then client 0 load of it
        txn(0, 1, 0, 1, 0, 32'd5, 32'd0, pat_a5, '0);
        txn(0, 1, 0, 0, 0, 32'd5, 32'd0, '0, '0);
        // Client 1 store line 7, load it, load aliased address
        txn(0, 0, 1, 0, 1, 32'd0, 32'd7, '0, pat_3c);
        txn(0, 0, 1, 0, 0, 32'd0, 32'd7, '0, '0);
        txn(0, 0, 1, 0, 0, 32'd0, 32'd7 + DEPTH0, '0, '0);

        // Tie after reset: client 0 first; then a client-0 round makes client 1 win
        do_reset(0);
        txn(0, 1, 1, 0, 0, 32'd5, 32'd7, '0, '0);
        txn(0, 1, 0, 0, 0, 32'd7, 32'd0, '0, '0);
        txn(0, 1, 1, 0, 0, 32'd7, 32'd5, '0, '0);
        txn(0, 1, 1, 0, 0, 32'd5, 32'd7, '0, '0);

        // Dirty-line miss: writeback then refill of a different line
        txn(0, 1, 0, 1, 0, 32'd40, 32'd0, rand_line(), '0);
        txn(0, 0, 1, 0, 1, 32'd0, 32'd30, '0, rand_line());
        txn(0, 0, 1, 0, 0, 32'd0, 32'd40, '0, '0);
        txn(0, 0, 1, 0, 0, 32'd0, 32'd30, '0, '0);

        // Reset mid-BUSY aborts a store to line 9
        old9 = rand_line();
        txn(0, 0, 1, 0, 1, 32'd0, 32'd9, '0, old9);
        abort_store(0, 1, 32'd9, ~old9, 2);
        txn(0, 1, 0, 0, 0, 32'd9, 32'd0, '0, '0);
        // Reset on the RESP-entry edge suppresses the write to line 11
        old11 = rand_line();
        txn(0, 1, 0, 1, 0, 32'd11, 32'd0, old11, '0);
        abort_store(0, 0, 32'd11, ~old11, LAT0);
        txn(0, 0, 1, 0, 0, 32'd0, 32'd11, '0, '0);

        // Randomized rounds over lines 16..23 with aliasing upper bits
        for (int i = 16; i < 24; i++)
            txn(0, i[0], !i[0], 1, 1, 32'(i), 32'(i), rand_line(), rand_line());
        for (int it = 0; it < 24; it++) begin
            int pat;
            pat = int'($urandom_range(0, 2));
            txn(0, pat != 1, pat != 0,
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                32'(16 + $urandom_range(0, 7) + DEPTH0 * $urandom_range(0, 3)),
                32'(16 + $urandom_range(0, 7) + DEPTH0 * $urandom_range(0, 3)),
                rand_line(), rand_line());
        end

        // LATENCY = 1 instance
        txn(1, 1, 0, 1, 0, 32'd3, 32'd0, rand_line(), '0);
        txn(1, 1, 0, 0, 0, 32'd3 + DEPTH1, 32'd0, '0, '0);
        txn(1, 1, 1, 1, 0, 32'd4, 32'd3, rand_line(), '0);
        txn(1, 1, 1, 0, 0, 32'd4, 32'd4, '0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
